// File: rtl/pingpong_pkg.sv
// Shared constants and state encoding for the ping-pong accumulator arbiter.
package pingpong_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_TURN = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pingpong_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer holds the last
// granted index and only moves when the top level reports a transfer.
module pingpong_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] masked;
    logic               found;

    // Requesters above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        hi_mask   = '0;
        grant_idx = '0;
        found     = 1'b0;
        grant     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = IDX_W'(i) > ptr;
        end
        masked = req_valid & hi_mask;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && masked[i]) begin
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= PTR_INIT;
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/pingpong_arbiter.sv
// Ping-pong accumulator shared by NUM_REQ round-robin requesters.
// Define PINGPONG_SAT_EN to saturate the add/subtract instead of wrapping.
module pingpong_arbiter
    import pingpong_pkg::*;
#(
    parameter  int unsigned NUM_REQ       = 4,
    parameter  int          MAX_THRESHOLD = 100,
    parameter  int          MIN_THRESHOLD = 0,
    localparam int unsigned IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         curr_reg_value,
    output logic                      dir,
    output logic [CNT_W-1:0]          bounce_count,
    output logic [IDX_W-1:0]          last_owner,
    output logic                      busy
);

    state_t                    state;
    state_t                    state_nxt;
    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      enable;
    logic                      transfer;
    logic                      any_valid;
    logic                      flip;
    logic signed [DATA_W-1:0]  acc;
    logic signed [DATA_W-1:0]  operand;
    logic signed [DATA_W-1:0]  raw;
    logic signed [DATA_W-1:0]  n;
    logic                      dir_q;
    logic [CNT_W-1:0]          bounce_q;
    logic [IDX_W-1:0]          owner_q;
`ifdef PINGPONG_SAT_EN
    logic                      ovf;
`endif

    assign enable    = rst && (state != ST_TURN);
    assign any_valid = |req_valid;
    assign transfer  = |(req_valid & grant);
    assign req_ready = grant;

    pingpong_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .enable    (enable),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        operand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                operand = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        raw = (dir_q == DIR_UP) ? acc + operand : acc - operand;
`ifdef PINGPONG_SAT_EN
        // Overflow is only possible when the result sign disagrees with acc.
        if (dir_q == DIR_UP) begin
            ovf = (acc[DATA_W-1] == operand[DATA_W-1]) && (raw[DATA_W-1] != acc[DATA_W-1]);
        end else begin
            ovf = (acc[DATA_W-1] != operand[DATA_W-1]) && (raw[DATA_W-1] != acc[DATA_W-1]);
        end
        if (ovf) begin
            n = acc[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            n = raw;
        end
`else
        n = raw;
`endif
        flip = (dir_q == DIR_UP) ? (n > MAX_THRESHOLD) : (n < MIN_THRESHOLD);
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_TURN: state_nxt = any_valid ? ST_RUN : ST_IDLE;
            default: begin
                if (transfer && flip) begin
                    state_nxt = ST_TURN;
                end else if (any_valid) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            dir_q    <= DIR_UP;
            bounce_q <= '0;
            owner_q  <= '0;
        end else begin
            state <= state_nxt;
            if (transfer) begin
                acc     <= n;
                owner_q <= grant_idx;
                if (flip) begin
                    dir_q    <= ~dir_q;
                    bounce_q <= bounce_q + CNT_W'(1);
                end
            end
        end
    end

    assign curr_reg_value = acc;
    assign dir            = dir_q;
    assign bounce_count   = bounce_q;
    assign last_owner     = owner_q;
    assign busy           = (state == ST_RUN) || (state == ST_TURN);

endmodule

// File: tb/tb_pingpong_arbiter.sv
// Scoreboard bench for pingpong_arbiter: a cycle model predicts grants and
// queues the post-edge accumulator state for every predicted transfer.
module tb_pingpong_arbiter;

    localparam int NUM = 4;
    localparam int MAXT = 100;
    localparam int MINT = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM-1:0]    req_valid;
    logic [32*NUM-1:0] req_data;
    logic [NUM-1:0]    req_ready;
    logic [31:0]       curr_reg_value;
    logic              dir;
    logic [15:0]       bounce_count;
    logic [1:0]        last_owner;
    logic              busy;

    always #5 clk = ~clk;

    pingpong_arbiter #(
        .NUM_REQ       (NUM),
        .MAX_THRESHOLD (MAXT),
        .MIN_THRESHOLD (MINT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .curr_reg_value (curr_reg_value),
        .dir            (dir),
        .bounce_count   (bounce_count),
        .last_owner     (last_owner),
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] acc;
        logic        dir;
        logic [15:0] bnc;
        logic [1:0]  owner;
    } exp_t;

    exp_t sb[$];

    int                 m_state;
    int                 m_ptr;
    logic signed [31:0] m_acc;
    logic               m_dir;
    logic [15:0]        m_bnc;
    logic [1:0]         m_owner;
    int                 n_checks;
    int                 n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] model_op(input logic signed [31:0] a,
                                                    input logic signed [31:0] x,
                                                    input logic down);
        longint s;
        s = down ? (longint'(a) - longint'(x)) : (longint'(a) + longint'(x));
`ifdef PINGPONG_SAT_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ptr   = NUM - 1;
        m_acc   = '0;
        m_dir   = 1'b0;
        m_bnc   = '0;
        m_owner = '0;
    endtask

    task automatic set_lane(input int r, input logic [31:0] v);
        req_data[32*r +: 32] = v;
    endtask

    // One clock: predict grant, check ready, advance the model, check outputs.
    task automatic step(output int gi);
        logic [NUM-1:0]     er;
        logic               rst_s;
        logic signed [31:0] x;
        logic signed [31:0] n;
        logic               flip;
        exp_t               e;
        int                 idx;
        @(negedge clk);
        rst_s = rst;
        gi    = -1;
        er    = '0;
        flip  = 1'b0;
        if (rst_s && m_state != 2) begin
            for (int off = 1; off <= NUM; off++) begin
                idx = (m_ptr + off) % NUM;
                if (gi < 0 && req_valid[idx]) gi = idx;
            end
        end
        if (gi >= 0) er[gi] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(er));
        if (!rst_s) begin
            model_reset();
        end else begin
            if (gi >= 0) begin
                x = req_data[32*gi +: 32];
                n = model_op(m_acc, x, m_dir);
                flip = m_dir ? (n < MINT) : (n > MAXT);
                m_acc   = n;
                m_owner = gi[1:0];
                m_ptr   = gi;
                if (flip) begin
                    m_dir = ~m_dir;
                    m_bnc = m_bnc + 16'd1;
                end
                e.acc = m_acc; e.dir = m_dir; e.bnc = m_bnc; e.owner = m_owner;
                sb.push_back(e);
            end
            if (m_state == 2) m_state = (|req_valid) ? 1 : 0;
            else if (gi >= 0 && flip) m_state = 2;
            else m_state = (|req_valid) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        if (!rst_s) begin
            check_eq("rst_acc", curr_reg_value, 32'd0);
            check_eq("rst_dir", 32'(dir), 32'd0);
            check_eq("rst_bounce", 32'(bounce_count), 32'd0);
            check_eq("rst_owner", 32'(last_owner), 32'd0);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("acc", curr_reg_value, e.acc);
            check_eq("dir", 32'(dir), 32'(e.dir));
            check_eq("bounce", 32'(bounce_count), 32'(e.bnc));
            check_eq("owner", 32'(last_owner), 32'(e.owner));
        end
        check_eq("busy", 32'(busy), 32'(m_state != 0));
    endtask

    task automatic send(input int r, input logic [31:0] v);
        int gi;
        bit done;
        done = 1'b0;
        set_lane(r, v);
        req_valid[r] = 1'b1;
        for (int k = 0; k < 10 && !done; k++) begin
            step(gi);
            if (gi == r) done = 1'b1;
        end
        check_eq("send_accepted", 32'(done), 32'd1);
        req_valid[r] = 1'b0;
    endtask

    task automatic do_reset();
        int gi;
        rst = 1'b0;
        step(gi);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gi;
        int t1_ops[6] = '{5, 10, 2, 3, 31, 50};
        int t2_ops[5] = '{70, 8, 3, 9, 12};
        int alt[4]    = '{1, 3, 1, 3};
        logic [31:0] held;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        model_reset();
        step(gi);
        step(gi);
        rst = 1'b1;

        // Single requester up-run until the first turn.
        foreach (t1_ops[i]) send(0, t1_ops[i]);
        check_eq("t1_acc", curr_reg_value, 32'd101);
        check_eq("t1_dir", 32'(dir), 32'd1);
        check_eq("t1_bounce", 32'(bounce_count), 32'd1);
        set_lane(0, 32'd70);
        req_valid[0] = 1'b1;
        #1;
        check_eq("t1_bubble_ready", 32'(req_ready), 32'd0);

        foreach (t2_ops[i]) send(0, t2_ops[i]);
        check_eq("t2_acc", curr_reg_value, 32'hFFFF_FFFF);
        check_eq("t2_dir", 32'(dir), 32'd0);
        check_eq("t2_bounce", 32'(bounce_count), 32'd2);

        // All requesters held valid: strict rotation from requester 0.
        do_reset();
        for (int r = 0; r < NUM; r++) set_lane(r, 32'(r + 1));
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step(gi);
            check_eq("t3_order", 32'(gi), 32'(k % NUM));
        end
        req_valid = '0;
        check_eq("t3_acc", curr_reg_value, 32'd20);
        check_eq("t3_owner", 32'(last_owner), 32'd3);
        step(gi);

        // Sparse requesters 1 and 3.
        req_valid = 4'b1010;
        foreach (alt[i]) begin
            step(gi);
            check_eq("t4_alt", 32'(gi), 32'(alt[i]));
        end
        step(gi);
        check_eq("t4_first", 32'(gi), 32'd1);
        req_valid = '0;
        held = curr_reg_value;
        step(gi);
        check_eq("t4_drop_none", 32'(gi), 32'hFFFF_FFFF);
        check_eq("t4_drop_acc", curr_reg_value, held);
        req_valid = 4'b1010;
        step(gi);
        check_eq("t4_ptr_hold", 32'(gi), 32'd3);
        req_valid = '0;
        step(gi);

        // Signed overflow on the add path.
        do_reset();
        send(0, 32'd50);
        send(0, 32'h7FFF_FFFF);
`ifdef PINGPONG_SAT_EN
        check_eq("t5_acc", curr_reg_value, 32'h7FFF_FFFF);
        check_eq("t5_dir", 32'(dir), 32'd1);
`else
        check_eq("t5_acc", curr_reg_value, 32'h8000_0031);
        check_eq("t5_dir", 32'(dir), 32'd0);
`endif

        // Reset in the middle of a stream.
        do_reset();
        set_lane(0, 32'd10);
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) step(gi);
        check_eq("t6_pre_acc", curr_reg_value, 32'd40);
        rst = 1'b0;
        step(gi);
        check_eq("t6_rst_grant", 32'(gi), 32'hFFFF_FFFF);
        check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        for (int r = 0; r < NUM; r++) set_lane(r, 32'(r + 7));
        req_valid = '1;
        step(gi);
        check_eq("t6_restart", 32'(gi), 32'd0);
        check_eq("t6_acc", curr_reg_value, 32'd7);
        req_valid = '0;
        step(gi);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pingpong_arbiter.md
Name: pingpong_arbiter

Overview:
- Shares one ping-pong accumulator between NUM_REQ requesters.
- Uses round-robin arbitration with a per-requester valid/ready handshake.
- Sequences the datapath: one accepted operand per cycle, plus a one-cycle bubble after every direction turn.
- Exposes accumulator value, direction and turn count to the surrounding design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_THRESHOLD, 100, signed upper bound; a result above it turns direction to down.
- MIN_THRESHOLD, 0, signed lower bound; a result below it turns direction to up.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  operand valid, one bit per requester.
- req_data  in  32*NUM_REQ  signed operands; requester i uses bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  one-hot grant; combinational from state and req_valid.
- curr_reg_value  out  32  accumulator value, two's complement.
- dir  out  1  0 = up (add), 1 = down (subtract).
- bounce_count  out  16  number of direction turns, wraps at 16 bits.
- last_owner  out  $clog2(NUM_REQ)  index of the most recently accepted requester.
- busy  out  1  high in RUN or TURN.

Behaviour:
- Reset (rst==0 at a posedge) forces:
  - curr_reg_value=0, dir=0, bounce_count=0, last_owner=0;
  - state IDLE, RR pointer = NUM_REQ-1, so requester 0 has highest priority first.
- Reset mid-operation discards any in-flight transfer. req_ready=0 while rst==0.
- States:
  - IDLE: no valid inputs. Go to RUN when any req_valid is high; req_ready is granted in the same cycle.
  - RUN: grant one requester per cycle. Go to TURN on an accepted operand that flips dir. Go to IDLE when no valid is present.
  - TURN: req_ready=0 for exactly one cycle. Then go to RUN if any valid is high, else IDLE.
- Arbitration:
  - Search starts at pointer+1 modulo NUM_REQ; the first set req_valid wins.
  - On transfer (valid&ready), the pointer moves to the granted index.
  - No transfer leaves the pointer unchanged.
- Datapath, for accepted operand x:
  - dir=0: n = acc + x; if n > MAX_THRESHOLD (signed), dir becomes 1.
  - dir=1: n = acc - x; if n < MIN_THRESHOLD (signed), dir becomes 0.
  - acc <= n. Latency is 1: curr_reg_value shows n after the accepting edge.
  - On a flip, bounce_count increments (wraps 0xFFFF→0).
  - last_owner updates on every transfer.
- Arithmetic: 32-bit modular wrap-around, no saturation (without the optional feature).
- A requester holds valid and data stable until ready. Dropping valid before grant is legal; the operand is simply not taken.
- Equality with a threshold does not turn.

Optional Feature:
- Macro: PINGPONG_SAT_EN.
- Defined: add/subtract saturate to 0x7FFFFFFF / 0x80000000 on signed overflow. The threshold compare uses the saturated value.
- Undefined: plain 32-bit wrap.

Decomposition:
- Package pingpong_pkg holds:
  - state encoding typedef (IDLE, RUN, TURN);
  - DATA_W=32 and CNT_W=16 constants;
  - direction constants DIR_UP=0, DIR_DOWN=1.
- Sub-module pingpong_rr_arbiter: NUM_REQ-wide round-robin grant with pointer register and advance-on-transfer input. The FSM and datapath stay in the top level.

Test Plan:
- Requester 0 only, operands 5,10,2,3,31,50 back-to-back → curr_reg_value=101, dir=1, bounce_count=1. The next cycle has req_ready=0 (TURN bubble).
- Continue with 70,8,3,9,12 → curr_reg_value=0xFFFFFFFF, dir=0, bounce_count=2.
- All four requesters valid with data 1,2,3,4, held for 8 cycles → grant order 0,1,2,3,0,1,2,3. Final curr_reg_value=20, last_owner=3.
- Requesters 1 and 3 valid only → alternating grants 1,3,1,3. Requester 3 drops valid while ungranted → no transfer from it, pointer unchanged.
- Overflow: acc=50 up, add 0x7FFFFFFF.
  - Wrap build → 0x80000031, dir stays 0.
  - PINGPONG_SAT_EN build → 0x7FFFFFFF, dir=1.
- Drive rst=0 for one cycle during a RUN stream at acc=40 → next cycle curr_reg_value=0, dir=0, bounce_count=0, req_ready=0. Arbitration restarts at requester 0.
